// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcode encoding and shared helpers for the RV32I ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int XLEN = 32;

    // Encoding is {funct7[5], funct3} so decode can feed the ALU directly.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b1000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SRA  = 4'b1101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111
    } alu_op_e;

    function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] din);
        logic [XLEN-1:0] dout;
        dout = '0;
        for (int i = 0; i < XLEN; i++) begin
            dout[i] = din[XLEN-1-i];
        end
        return dout;
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_shifter.sv
`default_nettype none
// ============================================================================
// Module      : alu_shifter
// Description : 5-stage logarithmic barrel shifter for SLL / SRL / SRA.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_shifter
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] data_in,
    input  logic [4:0]      shamt,
    input  logic            shift_left,
    input  logic            arith,
    output logic [XLEN-1:0] data_out
);

    // Left shifts reuse the right-shift network by mirroring the operand.
    logic [XLEN-1:0] stage [0:5];
    logic            fill;

    assign fill     = arith & ~shift_left & data_in[XLEN-1];
    assign stage[0] = shift_left ? bit_reverse(data_in) : data_in;

    genvar i;
    generate
        for (i = 0; i < 5; i++) begin : g_stage
            localparam int SH = 1 << i;
            assign stage[i+1] = shamt[i] ? {{SH{fill}}, stage[i][XLEN-1:SH]} : stage[i];
        end
    endgenerate

    assign data_out = shift_left ? bit_reverse(stage[5]) : stage[5];

endmodule : alu_shifter
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : RV32I integer ALU, combinational RESULT plus registered RESULT_Q.
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import alu_pkg::*;
(
    input  logic            CLK,
    input  logic            RESET,
    input  logic [XLEN-1:0] OP_1,
    input  logic [XLEN-1:0] OP_2,
    input  logic [3:0]      OPCODE,
    output logic [XLEN-1:0] RESULT,
    output logic [XLEN-1:0] RESULT_Q
);

    logic            subtract;
    logic [XLEN:0]   sum;
    logic            lt_signed;
    logic            lt_unsigned;
    logic [XLEN-1:0] shift_out;
    logic [XLEN-1:0] result_d;
    logic [XLEN-1:0] result_q;

    // One adder serves ADD, SUB and both compares; everything but ADD subtracts.
    assign subtract    = (OPCODE != ALU_ADD);
    assign sum         = {1'b0, OP_1} + {1'b0, OP_2 ^ {XLEN{subtract}}} + {{XLEN{1'b0}}, subtract};
    assign lt_unsigned = ~sum[XLEN];
    assign lt_signed   = (OP_1[XLEN-1] != OP_2[XLEN-1]) ? OP_1[XLEN-1] : sum[XLEN-1];

    alu_shifter u_shifter (
        .data_in    (OP_1),
        .shamt      (OP_2[4:0]),
        .shift_left (OPCODE == ALU_SLL),
        .arith      (OPCODE == ALU_SRA),
        .data_out   (shift_out)
    );

    always_comb begin
        RESULT = '0;
        case (OPCODE)
            ALU_ADD,
            ALU_SUB:  RESULT = sum[XLEN-1:0];
            ALU_SLT:  RESULT = {{(XLEN-1){1'b0}}, lt_signed};
            ALU_SLTU: RESULT = {{(XLEN-1){1'b0}}, lt_unsigned};
            ALU_XOR:  RESULT = OP_1 ^ OP_2;
            ALU_OR:   RESULT = OP_1 | OP_2;
            ALU_AND:  RESULT = OP_1 & OP_2;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  RESULT = shift_out;
            default:  RESULT = '0;
        endcase
    end

    always_comb begin
        result_d = RESULT;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign RESULT_Q = result_q;

endmodule : alu
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu
// Description : Self-checking bench for alu with a RESULT_Q scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] OP_1;
    logic [31:0] OP_2;
    logic [3:0]  OPCODE;
    logic [31:0] RESULT;
    logic [31:0] RESULT_Q;

    int n_vec  = 0;
    int n_miss = 0;
    logic [31:0] exp_q [$];

    alu dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .OP_1     (OP_1),
        .OP_2     (OP_2),
        .OPCODE   (OPCODE),
        .RESULT   (RESULT),
        .RESULT_Q (RESULT_Q)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << b[4:0];
            4'b0010: return {31'b0, ($signed(a) < $signed(b))};
            4'b0011: return {31'b0, (a < b)};
            4'b0100: return a ^ b;
            4'b0101: return a >> b[4:0];
            4'b1101: return $signed(a) >>> b[4:0];
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return 32'h0;
        endcase
    endfunction

    // Called just after a rising edge: drive, check RESULT, queue the registered value.
    task automatic apply(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic rst, input logic [31:0] exp);
        OPCODE = op;
        OP_1   = a;
        OP_2   = b;
        RESET  = rst;
        #1;
        check_eq({tag, ":res"}, RESULT, exp);
        exp_q.push_back(rst ? 32'h0 : exp);
        @(posedge CLK);
        #1;
        if (exp_q.size() > 0) begin
            check_eq({tag, ":res_q"}, RESULT_Q, exp_q.pop_front());
        end
    endtask

    logic [3:0] ops   [10] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                               4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};
    logic [3:0] undef [6]  = '{4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1110, 4'b1111};

    initial begin
        RESET  = 1'b1;
        OP_1   = 32'h0;
        OP_2   = 32'h0;
        OPCODE = 4'b0000;
        @(posedge CLK);
        #1;
        check_eq("reset", RESULT_Q, 32'h0);

        apply("add_ovf",  4'b0000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 32'h80000000);
        apply("add_wrap", 4'b0000, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000);
        apply("sub_ovf",  4'b1000, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF);
        apply("sub_neg",  4'b1000, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF);
        apply("sub_2",    4'b1000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 32'h00000002);
        apply("sub_fe",   4'b1000, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'hFFFFFFFE);
        apply("slt",      4'b0010, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000001);
        apply("sltu",     4'b0011, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000);
        apply("sra",      4'b1101, 32'h80000000, 32'hFFFFFFE4, 1'b0, 32'hF8000000);
        apply("srl",      4'b0101, 32'h80000000, 32'hFFFFFFE4, 1'b0, 32'h08000000);
        apply("sll",      4'b0001, 32'h00000001, 32'h0000003F, 1'b0, 32'h80000000);
        apply("xor",      4'b0100, 32'hF0F0A5A5, 32'h0FF05A5A, 1'b0, 32'hFF00FFFF);
        apply("or",       4'b0110, 32'hF0000001, 32'h0F000010, 1'b0, 32'hFF000011);
        apply("and",      4'b0111, 32'hF0F0FFFF, 32'h0FF01234, 1'b0, 32'h00F01234);
        apply("slt_eq",   4'b0010, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000);
        apply("sltu_lt",  4'b0011, 32'h00000001, 32'hFFFFFFFF, 1'b0, 32'h00000001);

        // Reset clears only the register; RESULT keeps tracking the inputs.
        apply("rst_mid",  4'b0000, 32'h00000002, 32'h00000003, 1'b1, 32'h00000005);
        apply("post_rst", 4'b0000, 32'h00000002, 32'h00000003, 1'b0, 32'h00000005);

        foreach (undef[k]) begin
            apply($sformatf("undef_%b", undef[k]), undef[k], 32'hDEADBEEF, 32'h12345678,
                  1'b0, 32'h0);
        end

        foreach (ops[k]) begin
            for (int n = 0; n < 200; n++) begin
                logic [31:0] a;
                logic [31:0] b;
                a = $urandom;
                b = $urandom;
                if (n < 4) begin
                    a = (n[0]) ? 32'h80000000 : a;
                    b = (n[1]) ? 32'h80000000 : b;
                end
                apply($sformatf("rnd_%b", ops[k]), ops[k], a, b, 1'b0, ref_alu(ops[k], a, b));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_alu
`default_nettype wire
